// File: rtl/demux_writer.sv
// Write-side demux: queues {sel, data} requests in an in-order FIFO and drains
// each one into destination register A..D once that destination is ready.
module demux_writer #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sel,
  input  logic [7:0] in_data,
  input  logic [3:0] dest_ready,
  output logic [3:0] load,
  output logic [7:0] A_q,
  output logic [7:0] B_q,
  output logic [7:0] C_q,
  output logic [7:0] D_q,
  output logic [2:0] pend_cnt
);

  localparam logic [1:0] LAST_PTR  = 2'(DEPTH - 1);
  localparam logic [2:0] DEPTH_CNT = 3'(DEPTH);

  // Storage is sized for the largest legal DEPTH; pointers wrap at DEPTH.
  logic [9:0] fifo_q [4];
  logic [7:0] dest_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] load_q, load_d;

  logic       push, pop;
  logic [1:0] head_sel;
  logic [7:0] head_data;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  assign head_sel  = fifo_q[rd_ptr_q][9:8];
  assign head_data = fifo_q[rd_ptr_q][7:0];

  // Full blocks acceptance even when the head pops on the same edge.
  assign in_ready = ~rst & (cnt_q < DEPTH_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = (cnt_q != 3'd0) & dest_ready[head_sel];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    load_d   = 4'b0000;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      load_d   = 4'b0001 << head_sel;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      load_q   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 10'd0;
        dest_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      if (push) fifo_q[wr_ptr_q] <= {in_sel, in_data};
      if (pop) dest_q[head_sel] <= head_data;
    end
  end

  assign load     = load_q;
  assign pend_cnt = cnt_q;
  assign A_q      = dest_q[0];
  assign B_q      = dest_q[1];
  assign C_q      = dest_q[2];
  assign D_q      = dest_q[3];

endmodule

// File: doc/demux_writer.md
Name: demux_writer

Overview:
- Write-side counterpart of the CPU's 4:1 8-bit source-select mux.
- Accepts 8-bit write requests that carry a 2-bit destination select, and routes each one to one of four 8-bit destination registers (A..D).
- Requests are queued in a small in-order FIFO and drained into the selected register only when that destination signals ready.
- Each write is announced by a one-cycle one-hot load strobe. The block sits between the datapath result bus and the register/port write-back.

Parameters:
- DEPTH, 2, request FIFO depth in entries; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  write request present.
- in_ready  out  1  block can accept a request this cycle.
- in_sel  in  2  destination: 0=A, 1=B, 2=C, 3=D.
- in_data  in  8  write data, bit 7 MSB.
- dest_ready  in  4  per-destination ready, bit n = destination n.
- load  out  4  one-hot write strobe, registered, one cycle per write.
- A_q  out  8  destination register 0.
- B_q  out  8  destination register 1.
- C_q  out  8  destination register 2.
- D_q  out  8  destination register 3.
- pend_cnt  out  3  number of queued, unissued requests (0..DEPTH).

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset, while rst is high:
  - A_q = B_q = C_q = D_q = 8'h00, load = 4'b0000, pend_cnt = 0.
  - All queued entries are discarded. in_ready is forced to 0.
  - After rst deasserts, in_ready = 1 in the first cycle.
- Reset mid-operation: pending writes are lost and no load strobe is emitted for them.
- in_ready = (pend_cnt < DEPTH) and not rst. in_ready has no combinational dependence on in_valid, in_sel, in_data or dest_ready.
- Accept: a request is accepted at a rising edge where in_valid and in_ready are both 1. {in_sel, in_data} are pushed at the FIFO tail.
- Source protocol: the source must hold in_valid, in_sel and in_data stable until the request is accepted. A request not accepted is not recorded.
- Issue: at a rising edge where the FIFO is non-empty and dest_ready[head.sel] = 1, the block:
  - writes head.data into the register selected by head.sel;
  - sets load to the one-hot code of head.sel for the following cycle;
  - pops the head.
- Otherwise load = 4'b0000 after that edge.
- At most one issue per cycle.
- Register holding: unselected registers hold their value. A destination register changes only on its own issue.
- Ordering: strictly in order, with head-of-line blocking. A stalled head blocks later entries even when their destinations are ready.
- Latency: a request accepted at edge N into an empty FIFO, with its destination ready, issues at edge N+1. load and the register update are therefore visible in the cycle after edge N+1. There is no bypass path; minimum latency is 2 edges.
- Throughput: 1 request per cycle when destinations are ready (simultaneous push and pop).
- Full: when pend_cnt = DEPTH, in_ready = 0 even if a pop occurs at the same edge. There is no pass-through when full.
- Empty: no issue occurs; dest_ready is ignored.
- pend_cnt update per edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop, or on neither.
- Repeated writes to the same destination on consecutive cycles produce consecutive load pulses; the last data wins.
- The FIFO is implemented with read/write pointers that wrap modulo DEPTH, plus a count register. Pointer wrap must not corrupt order.

Test Plan:
- Reset defaults: assert rst asynchronously (not clock-aligned) -> immediately A_q..D_q = 00, load = 0000, pend_cnt = 0, in_ready = 0. Deassert rst -> in_ready = 1.
- Single write: dest_ready = 1111, push sel = 2, data = 5A at edge N -> load = 0100 for exactly one cycle after edge N+1. C_q = 5A; A_q, B_q and D_q unchanged at 00.
- Back-to-back: push (0,11), (3,33), (0,22) on consecutive cycles, all destinations ready:
  - load sequence is 0001, 1000, 0001 on consecutive cycles;
  - final A_q = 22, D_q = 33;
  - in_ready stays 1 and pend_cnt never exceeds 1.
- Stall and head-of-line blocking: dest_ready = 1101, DEPTH = 2, present (1,AA), (0,BB), (2,CC):
  - first two are accepted, pend_cnt = 2, in_ready = 0, CC is held at the input;
  - A_q stays 00 and no load occurs.
  - Then raise dest_ready[1] -> loads 0010, 0001, 0100 in order; final B_q = AA, A_q = BB, C_q = CC.
- Full with simultaneous pop: FIFO full, head destination ready, in_valid = 1 -> no accept at that edge; pend_cnt goes 2 to 1; the request is accepted at the next edge.
- Reset mid-operation: 2 entries pending with destinations stalled, pulse rst -> pend_cnt = 0 and all registers 00. Releasing dest_ready afterwards -> no load pulses.
